data_mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/data_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder and its lane aligner.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    localparam int CNT_W = 4;

    // Misaligned, reserved-size or out-of-range requests are rejected.
    function automatic logic req_error(input logic [31:0] addr,
                                       input logic [1:0]  size,
                                       input logic [29:0] limit);
        logic e;
        case (size)
            2'd0:    e = 1'b0;
            2'd1:    e = addr[0];
            2'd2:    e = (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e | (addr[31:2] >= limit);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables / replicated lanes, and
// load extraction with sign or zero extension. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] lane_wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] rdata
);

    logic [31:0] shifted_s;

    // Lane generation for stores and extraction/extension for loads.
    always_comb begin
        lane_wdata = 32'd0;
        byte_en    = 4'b0000;
        rdata      = 32'd0;
        shifted_s  = rword >> {addr_lo, 3'b000};
        case (size)
            SZ_B: begin
                byte_en    = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                if (is_unsigned) begin
                    rdata = {24'd0, shifted_s[7:0]};
                end else begin
                    rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                if (is_unsigned) begin
                    rdata = {16'd0, shifted_s[15:0]};
                end else begin
                    rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_W: begin
                byte_en    = 4'b1111;
                lane_wdata = wdata;
                rdata      = rword;
            end
            default: begin
                byte_en    = 4'b0000;
                lane_wdata = 32'd0;
                rdata      = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request port, fixed-latency response,
// byte-enabled word array with little-endian lane steering.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ENTRY_COUNT = 32,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int             IDX_W     = $clog2(ENTRY_COUNT);
    localparam logic [29:0]    ENTRY_LIM = 30'(ENTRY_COUNT);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (LATENCY > 1) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};

    resp_state_e      state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             ready_r, resp_valid_r, resp_err_r;
    logic [31:0]      resp_rdata_r;
    logic             accept_s;

    logic             hold_we_r, hold_uns_r;
    logic [31:0]      hold_addr_r, hold_wdata_r;
    logic [1:0]       hold_size_r;

    logic             sel_we_s, sel_uns_s;
    logic [31:0]      sel_addr_s, sel_wdata_s;
    logic [1:0]       sel_size_s;

    logic             err_s, in_range_s, mem_we_s;
    logic [31:0]      rword_s, lane_wdata_s, rdata_ext_s;
    logic [3:0]       byte_en_s;
    logic [IDX_W-1:0] word_idx_s;
    logic [31:0]      mem_r [ENTRY_COUNT];

    assign accept_s   = req_valid && ready_r;
    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // In WAIT the held request drives the datapath; otherwise the live one
    // (a store or a LATENCY==1 load completes on its acceptance edge).
    always_comb begin
        if (state_r == WAIT) begin
            sel_we_s    = hold_we_r;
            sel_uns_s   = hold_uns_r;
            sel_addr_s  = hold_addr_r;
            sel_wdata_s = hold_wdata_r;
            sel_size_s  = hold_size_r;
        end else begin
            sel_we_s    = req_we;
            sel_uns_s   = req_unsigned;
            sel_addr_s  = req_addr;
            sel_wdata_s = req_wdata;
            sel_size_s  = req_size;
        end
    end

    // Error decode and guarded array read for the selected request.
    always_comb begin
        err_s      = req_error(sel_addr_s, sel_size_s, ENTRY_LIM);
        in_range_s = (sel_addr_s[31:2] < ENTRY_LIM);
        word_idx_s = sel_addr_s[IDX_W+1:2];
        mem_we_s   = accept_s && req_we && !err_s;
        if (in_range_s) begin
            rword_s = mem_r[word_idx_s];
        end else begin
            rword_s = 32'd0;
        end
    end

    mem_lane_align u_align (
        .addr_lo     (sel_addr_s[1:0]),
        .size        (mem_size_e'(sel_size_s)),
        .is_unsigned (sel_uns_s),
        .wdata       (sel_wdata_s),
        .rword       (rword_s),
        .lane_wdata  (lane_wdata_s),
        .byte_en     (byte_en_s),
        .rdata       (rdata_ext_s)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE, RESP: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        next_state_s = RESP;
                    end else begin
                        next_state_s = WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered handshake/response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            state_r      <= next_state_s;
            cnt_r        <= cnt_next_s;
            ready_r      <= (next_state_s != WAIT);
            resp_valid_r <= (next_state_s == RESP);
            if (next_state_s == RESP) begin
                resp_err_r   <= err_s;
                resp_rdata_r <= (err_s || sel_we_s) ? 32'd0 : rdata_ext_s;
            end
        end
    end

    // Request capture for multi-cycle latencies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_we_r    <= 1'b0;
            hold_uns_r   <= 1'b0;
            hold_addr_r  <= 32'd0;
            hold_wdata_r <= 32'd0;
            hold_size_r  <= 2'd0;
        end else if (accept_s) begin
            hold_we_r    <= req_we;
            hold_uns_r   <= req_unsigned;
            hold_addr_r  <= req_addr;
            hold_wdata_r <= req_wdata;
            hold_size_r  <= req_size;
        end
    end

    // Word array with per-byte write enables; cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= lane_wdata_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 3) driven from one
// directed op list and checked every cycle against a behavioural model.
module tb_data_mem_responder;

    localparam int OP_REQ  = 0;
    localparam int OP_IDLE = 1;
    localparam int OP_RST  = 2;

    typedef struct {
        int          inst;
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] pin;
        logic        pin_err;
    } op_t;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst          [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic        resp_valid   [3];
    logic [31:0] resp_rdata   [3];
    logic        resp_err     [3];

    op_t         ops [$];
    exp_t        pend [$];
    logic [31:0] mem_m [3][32];
    logic [31:0] hold_rdata [3];
    logic        hold_err [3];
    int          ncnt;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            data_mem_responder #(.ENTRY_COUNT(32), .LATENCY(g + 1)) u_dut (
                .clk          (clk),
                .rst          (rst[g]),
                .req_valid    (req_valid[g]),
                .req_ready    (req_ready[g]),
                .req_we       (req_we[g]),
                .req_addr     (req_addr[g]),
                .req_wdata    (req_wdata[g]),
                .req_size     (req_size[g]),
                .req_unsigned (req_unsigned[g]),
                .resp_valid   (resp_valid[g]),
                .resp_rdata   (resp_rdata[g]),
                .resp_err     (resp_err[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (LATENCY=%0d) at cycle %0d: got %h, expected %h", name, k + 1, ncnt, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || ((a >> 2) >= 32'd32);
    endfunction

    function automatic logic [31:0] m_load(input int k, input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        v = mem_m[k][a >> 2] >> (8 * a[1:0]);
        if (sz == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic m_store(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        int n;
        int pos;
        logic [31:0] w;
        logic [31:0] bv;
        n = 1 << sz;
        w = mem_m[k][a >> 2];
        for (int j = 0; j < n; j++) begin
            bv  = (wd >> (8 * j)) & 32'h0000_00FF;
            pos = int'(a[1:0]) + j;
            w   = (w & ~(32'h0000_00FF << (8 * pos))) | (bv << (8 * pos));
        end
        mem_m[k][a >> 2] = w;
    endtask

    task automatic m_reset(input int k);
        for (int i = 0; i < 32; i++) mem_m[k][i] = 32'd0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].inst == k) pend.delete(i);
        end
        hold_rdata[k] = 32'd0;
        hold_err[k]   = 1'b0;
    endtask

    task automatic rq(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns, input logic [31:0] pin, input logic perr);
        op_t o;
        o.inst = k; o.kind = OP_REQ; o.we = we; o.addr = a; o.wdata = wd;
        o.size = sz; o.uns = uns; o.pin = pin; o.pin_err = perr;
        ops.push_back(o);
    endtask

    task automatic ctl(input int k, input int kind, input int n);
        op_t o;
        o.inst = k; o.kind = kind; o.we = 1'b0; o.addr = 32'd0; o.wdata = 32'd0;
        o.size = 2'd0; o.uns = 1'b0; o.pin = 32'd0; o.pin_err = 1'b0;
        for (int i = 0; i < n; i++) ops.push_back(o);
    endtask

    task automatic check_all();
        logic exp_v;
        logic exp_rdy;
        int   idx;
        for (int k = 0; k < 3; k++) begin
            exp_v = 1'b0; exp_rdy = 1'b1; idx = -1;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].inst == k) begin
                    if (pend[i].due == ncnt) begin
                        exp_v = 1'b1; idx = i;
                    end else if (pend[i].due > ncnt) begin
                        exp_rdy = 1'b0;
                    end
                end
            end
            chk("req_ready", k, {31'd0, req_ready[k]}, {31'd0, exp_rdy});
            chk("resp_valid", k, {31'd0, resp_valid[k]}, {31'd0, exp_v});
            if (idx >= 0) begin
                hold_rdata[k] = pend[idx].rdata;
                hold_err[k]   = pend[idx].err;
                pend.delete(idx);
            end
            chk("resp_rdata", k, resp_rdata[k], hold_rdata[k]);
            chk("resp_err", k, {31'd0, resp_err[k]}, {31'd0, hold_err[k]});
        end
    endtask

    task automatic drive_step();
        op_t         o;
        exp_t        e;
        logic        er;
        logic [31:0] rd;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0;
            req_valid[k] = 1'b0;
        end
        if (ops.size() > 0) begin
            o = ops[0];
            if (o.kind == OP_IDLE) begin
                void'(ops.pop_front());
            end else if (o.kind == OP_RST) begin
                rst[o.inst] = 1'b1;
                m_reset(o.inst);
                void'(ops.pop_front());
            end else begin
                req_valid[o.inst]    = 1'b1;
                req_we[o.inst]       = o.we;
                req_addr[o.inst]     = o.addr;
                req_wdata[o.inst]    = o.wdata;
                req_size[o.inst]     = o.size;
                req_unsigned[o.inst] = o.uns;
                if (req_ready[o.inst] === 1'b1) begin
                    er = m_err(o.addr, o.size);
                    if (!er && o.we) m_store(o.inst, o.addr, o.wdata, o.size);
                    rd = (er || o.we) ? 32'd0 : m_load(o.inst, o.addr, o.size, o.uns);
                    chk("model_rdata", o.inst, rd, o.pin);
                    chk("model_err", o.inst, {31'd0, er}, {31'd0, o.pin_err});
                    e.inst = o.inst; e.due = ncnt + o.inst + 1; e.rdata = rd; e.err = er;
                    pend.push_back(e);
                    void'(ops.pop_front());
                end
            end
        end
    endtask

    initial begin
        int  cyc;
        logic done;
        n_checks = 0; n_fail = 0; ncnt = 0; done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'd0;
            req_wdata[k] = 32'd0; req_size[k] = 2'd0; req_unsigned[k] = 1'b0;
            m_reset(k);
        end

        // LATENCY=2: word store/load, extension cases, error cases, lane merges.
        rq(1, 1'b1, 32'h8,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0);
        rq(1, 1'b0, 32'h8,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
        rq(1, 1'b0, 32'hB,  32'h0,        2'd0, 1'b0, 32'hFFFFFFDE, 1'b0);
        rq(1, 1'b0, 32'hB,  32'h0,        2'd0, 1'b1, 32'h000000DE, 1'b0);
        rq(1, 1'b0, 32'hA,  32'h0,        2'd1, 1'b0, 32'hFFFFDEAD, 1'b0);
        rq(1, 1'b0, 32'h8,  32'h0,        2'd1, 1'b1, 32'h0000BEEF, 1'b0);
        rq(1, 1'b1, 32'h9,  32'h1234,     2'd1, 1'b0, 32'h0,        1'b1);
        rq(1, 1'b0, 32'h8,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
        rq(1, 1'b0, 32'h80, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1);
        rq(1, 1'b0, 32'h0,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1);
        rq(1, 1'b1, 32'h9,  32'hFFFFFF5A, 2'd0, 1'b0, 32'h0,        1'b0);
        rq(1, 1'b1, 32'hA,  32'h0000CAFE, 2'd1, 1'b0, 32'h0,        1'b0);
        rq(1, 1'b0, 32'h8,  32'h0,        2'd2, 1'b0, 32'hCAFE5AEF, 1'b0);
        rq(1, 1'b1, 32'h7C, 32'h12345678, 2'd2, 1'b0, 32'h0,        1'b0);
        rq(1, 1'b0, 32'h7E, 32'h0,        2'd1, 1'b0, 32'h00001234, 1'b0);
        rq(1, 1'b0, 32'h6,  32'h0,        2'd2, 1'b0, 32'h0,        1'b1);
        ctl(1, OP_IDLE, 3);
        // LATENCY=1: back-to-back requests.
        rq(0, 1'b1, 32'h0,  32'h11,       2'd0, 1'b0, 32'h0,        1'b0);
        rq(0, 1'b0, 32'h0,  32'h0,        2'd2, 1'b0, 32'h00000011, 1'b0);
        rq(0, 1'b1, 32'h1,  32'h80,       2'd0, 1'b0, 32'h0,        1'b0);
        rq(0, 1'b0, 32'h0,  32'h0,        2'd1, 1'b0, 32'hFFFF8011, 1'b0);
        rq(0, 1'b0, 32'h0,  32'h0,        2'd1, 1'b1, 32'h00008011, 1'b0);
        ctl(0, OP_IDLE, 3);
        // LATENCY=3: second request held through WAIT.
        rq(2, 1'b0, 32'h0,  32'h0,        2'd2, 1'b0, 32'h0,        1'b0);
        rq(2, 1'b1, 32'h4,  32'hA5A5A5A5, 2'd2, 1'b0, 32'h0,        1'b0);
        rq(2, 1'b0, 32'h5,  32'h0,        2'd0, 1'b0, 32'hFFFFFFA5, 1'b0);
        ctl(2, OP_IDLE, 4);
        // LATENCY=2: reset one cycle after accepting a load.
        rq(1, 1'b0, 32'h8,  32'h0,        2'd2, 1'b0, 32'hCAFE5AEF, 1'b0);
        ctl(1, OP_RST, 1);
        ctl(1, OP_IDLE, 2);
        rq(1, 1'b0, 32'h8,  32'h0,        2'd2, 1'b0, 32'h0,        1'b0);
        rq(1, 1'b0, 32'h7C, 32'h0,        2'd2, 1'b0, 32'h0,        1'b0);
        ctl(1, OP_IDLE, 4);

        #2;
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;

        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            ncnt++;
            cyc++;
            check_all();
            drive_step();
            done = (ops.size() == 0) && (pend.size() == 0);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d ops and %0d responses outstanding, expected 0", ops.size(), pend.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
